// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader and its byte receiver.
// LOADER_CHECKSUM_EN adds the CSUM state to the loader FSM.
package loader_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         CNT_W         = 9;
   localparam int         IDX_W         = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_COUNT = 3'd1,
      ST_DATA  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM  = 3'd3,
`endif
      ST_ERR   = 3'd4
   } loader_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   // A count byte of zero encodes a full 256-word frame.
   function automatic logic [CNT_W-1:0] decode_count(input logic [7:0] b);
      return (b == 8'd0) ? 9'd256 : {1'b0, b};
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting start.
// byte_valid_o pulses once per received byte with stop_err_o set when the stop bit was low.
module uart_rx_byte
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clock,
   input  logic       reset_i,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       stop_err_o
);

   localparam int            CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   rx_state_e     state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          meta_q;
   logic          sync_q;
   logic          prev_q;

   // Synchronizer, bit timer and shift register.
   always_ff @(posedge clock or negedge reset_i) begin
      if (!reset_i) begin
         meta_q       <= 1'b1;
         sync_q       <= 1'b1;
         prev_q       <= 1'b1;
         state_q      <= RX_IDLE;
         cnt_q        <= '0;
         bit_q        <= 3'd0;
         shift_q      <= 8'h00;
         byte_o       <= 8'h00;
         byte_valid_o <= 1'b0;
         stop_err_o   <= 1'b0;
      end else begin
         meta_q       <= rx_i;
         sync_q       <= meta_q;
         prev_q       <= sync_q;
         byte_valid_o <= 1'b0;
         stop_err_o   <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               cnt_q <= '0;
               if (prev_q && !sync_q) state_q <= RX_START;
               else                   state_q <= RX_IDLE;
            end
            RX_START: begin
               // A line that is high again at mid start bit was a glitch.
               if (cnt_q == HALF_M1) begin
                  cnt_q   <= '0;
                  bit_q   <= 3'd0;
                  state_q <= sync_q ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q   <= '0;
                  shift_q <= {sync_q, shift_q[7:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) state_q <= RX_STOP;
                  else               state_q <= RX_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q        <= '0;
                  byte_o       <= shift_q;
                  byte_valid_o <= 1'b1;
                  stop_err_o   <= !sync_q;
                  state_q      <= RX_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_prog_loader.sv
// Framed UART image loader writing 32-bit words into core memory while holding the core in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module uart_prog_loader
   import loader_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 868,
   parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
   parameter int          TIMEOUT_CYC  = 2000000,
   parameter logic [31:0] BASE_ADDR    = 32'h0
) (
   input  logic             clock,
   input  logic             reset_i,
   input  logic             rx_i,
   output logic             mem_we_o,
   output logic [31:0]      mem_addr_o,
   output logic [31:0]      mem_data_o,
   output logic             core_hold_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [CNT_W-1:0] words_o
);

   localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [7:0] rx_byte_s;
   logic       byte_valid_s;
   logic       stop_err_s;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clock        (clock),
      .reset_i      (reset_i),
      .rx_i         (rx_i),
      .byte_o       (rx_byte_s),
      .byte_valid_o (byte_valid_s),
      .stop_err_o   (stop_err_s)
   );

   loader_state_e    state_q;
   logic [CNT_W-1:0] n_q;
   logic [CNT_W-1:0] words_q;
   logic [IDX_W-1:0] idx_q;
   logic [31:0]      word_q;
   logic [TW-1:0]    to_q;
   logic             mem_we_q;
   logic [31:0]      mem_addr_q;
   logic [31:0]      mem_data_q;
   logic             hold_q;
   logic             done_q;
   logic             err_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]       xor_q;
`endif

   // Frame FSM with registered memory strobe and status outputs.
   always_ff @(posedge clock or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= ST_IDLE;
         n_q        <= '0;
         words_q    <= '0;
         idx_q      <= '0;
         word_q     <= 32'h0;
         to_q       <= '0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= 32'h0;
         mem_data_q <= 32'h0;
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         xor_q      <= 8'h00;
`endif
      end else begin
         mem_we_q <= 1'b0;
         done_q   <= 1'b0;
         if (state_q == ST_IDLE || state_q == ST_ERR || byte_valid_s) to_q <= '0;
         else                                                        to_q <= to_q + 1'b1;

         case (state_q)
            ST_IDLE: begin
               if (byte_valid_s && !stop_err_s && rx_byte_s == SYNC_BYTE) begin
                  state_q <= ST_COUNT;
                  err_q   <= 1'b0;
                  words_q <= '0;
                  hold_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  xor_q   <= 8'h00;
`endif
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_COUNT: begin
               if (byte_valid_s && !stop_err_s) begin
                  n_q     <= decode_count(rx_byte_s);
                  idx_q   <= '0;
                  state_q <= ST_DATA;
               end else if (byte_valid_s || to_q == TO_LAST) begin
                  state_q <= ST_ERR;
                  err_q   <= 1'b1;
                  hold_q  <= 1'b0;
               end else begin
                  state_q <= ST_COUNT;
               end
            end
            ST_DATA: begin
               if (byte_valid_s && !stop_err_s) begin
                  word_q[{idx_q, 3'b000} +: 8] <= rx_byte_s;
                  idx_q <= idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  xor_q <= xor_q ^ rx_byte_s;
`endif
                  if (idx_q == 2'd3) begin
                     mem_we_q   <= 1'b1;
                     mem_addr_q <= BASE_ADDR + {21'd0, words_q, 2'b00};
                     mem_data_q <= {rx_byte_s, word_q[23:0]};
                     words_q    <= words_q + 1'b1;
                     if (words_q + 9'd1 == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q <= ST_CSUM;
`else
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
`endif
                     end else begin
                        state_q <= ST_DATA;
                     end
                  end else begin
                     state_q <= ST_DATA;
                  end
               end else if (byte_valid_s || to_q == TO_LAST) begin
                  // The partially assembled word is simply never written.
                  state_q <= ST_ERR;
                  err_q   <= 1'b1;
                  hold_q  <= 1'b0;
               end else begin
                  state_q <= ST_DATA;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (byte_valid_s && !stop_err_s && rx_byte_s == xor_q) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
                  hold_q  <= 1'b0;
               end else if (byte_valid_s || to_q == TO_LAST) begin
                  state_q <= ST_ERR;
                  err_q   <= 1'b1;
                  hold_q  <= 1'b0;
               end else begin
                  state_q <= ST_CSUM;
               end
            end
`endif
            ST_ERR:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_data_o  = mem_data_q;
   assign core_hold_o = hold_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign words_o     = words_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected writes queued as frames are sent,
// popped and compared on every mem_we_o strobe.
module tb_uart_prog_loader;

   localparam int CPB = 8;
   localparam int TO  = 2000;

   logic        clock   = 1'b0;
   logic        reset_i = 1'b0;
   logic        rx_i    = 1'b1;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        core_hold_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [8:0]  words_o;

   int total    = 0;
   int bad      = 0;
   int done_cnt = 0;
   int we_cnt   = 0;
   int bv_cnt   = 0;
   logic [63:0] exp_q[$];
   logic [63:0] exp_e;

   uart_prog_loader #(
      .CLKS_PER_BIT (CPB),
      .SYNC_BYTE    (8'hA5),
      .TIMEOUT_CYC  (TO),
      .BASE_ADDR    (32'h0)
   ) dut (
      .clock       (clock),
      .reset_i     (reset_i),
      .rx_i        (rx_i),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_data_o  (mem_data_o),
      .core_hold_o (core_hold_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .words_o     (words_o)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest queued expectation.
   always @(negedge clock) begin
      if (reset_i) begin
         if (dut.u_rx.byte_valid_o) bv_cnt++;
         if (done_o) begin
            done_cnt++;
            chk("hold_at_done", {63'd0, core_hold_o}, 64'd0);
         end
         if (mem_we_o) begin
            we_cnt++;
            chk("we_expected", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
               exp_e = exp_q.pop_front();
               chk("we_addr", {32'd0, mem_addr_o}, {32'd0, exp_e[63:32]});
               chk("we_data", {32'd0, mem_data_o}, {32'd0, exp_e[31:0]});
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx_i = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (CPB) @(negedge clock);
      end
      rx_i = stop_bit;
      repeat (CPB) @(negedge clock);
      rx_i = 1'b1;
   endtask

   // Sends SYNC, count, data and (when enabled) the XOR checksum ^ csum_flip; queues expected writes.
   task automatic send_frame(input logic [7:0] n_byte, input logic [7:0] d[$], input logic [7:0] csum_flip);
      logic [7:0] x;
      x = 8'h00;
      for (int j = 0; j < d.size() / 4; j++)
         exp_q.push_back({32'(4 * j), d[4*j+3], d[4*j+2], d[4*j+1], d[4*j]});
      send_byte(8'hA5, 1'b1);
      send_byte(n_byte, 1'b1);
      foreach (d[k]) begin
         x = x ^ d[k];
         send_byte(d[k], 1'b1);
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(x ^ csum_flip, 1'b1);
`else
      if (csum_flip != 8'h00) x = 8'h00;
`endif
   endtask

   initial begin
      int d0;
      int w0;
      int b0;
      logic [7:0] da[$];
      logic [7:0] dbig[$];
      da = '{8'h78, 8'h56, 8'h34, 8'h12};
      for (int i = 0; i < 1024; i++) dbig.push_back(8'(i));

      repeat (3) @(negedge clock);
      chk("rst_ctl", {50'd0, mem_we_o, core_hold_o, busy_o, done_o, err_o, words_o}, 64'd0);
      chk("rst_addr", {32'd0, mem_addr_o}, 64'd0);
      chk("rst_data", {32'd0, mem_data_o}, 64'd0);
      reset_i = 1'b1;
      repeat (5) @(negedge clock);

      // Single-word frame, with hold checked mid-frame.
      d0 = done_cnt;
      exp_q.push_back({32'h0, 32'h12345678});
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      chk("A_hold_mid", {63'd0, core_hold_o}, 64'd1);
      chk("A_busy_mid", {63'd0, busy_o}, 64'd1);
      foreach (da[k]) send_byte(da[k], 1'b1);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h08, 1'b1);
`endif
      repeat (4) @(negedge clock);
      chk("A_done", 64'(done_cnt - d0), 64'd1);
      chk("A_words", {55'd0, words_o}, 64'd1);
      chk("A_err", {63'd0, err_o}, 64'd0);
      chk("A_hold_end", {63'd0, core_hold_o}, 64'd0);
      chk("A_drain", 64'(exp_q.size()), 64'd0);

      // Full 256-word frame.
      d0 = done_cnt;
      w0 = we_cnt;
      send_frame(8'h00, dbig, 8'h00);
      repeat (4) @(negedge clock);
      chk("B_done", 64'(done_cnt - d0), 64'd1);
      chk("B_writes", 64'(we_cnt - w0), 64'd256);
      chk("B_words", {55'd0, words_o}, 64'd256);
      chk("B_last_addr", {32'd0, mem_addr_o}, 64'h3FC);
      chk("B_drain", 64'(exp_q.size()), 64'd0);

`ifdef LOADER_CHECKSUM_EN
      // Bad checksum: the word is still written but the frame is flagged.
      d0 = done_cnt;
      w0 = we_cnt;
      send_frame(8'h01, da, 8'h01);
      repeat (4) @(negedge clock);
      chk("C_err", {63'd0, err_o}, 64'd1);
      chk("C_no_done", 64'(done_cnt - d0), 64'd0);
      chk("C_write", 64'(we_cnt - w0), 64'd1);
      chk("C_hold", {63'd0, core_hold_o}, 64'd0);
      send_frame(8'h01, da, 8'h00);
      repeat (4) @(negedge clock);
      chk("C_err_clr", {63'd0, err_o}, 64'd0);
      chk("C_redone", 64'(done_cnt - d0), 64'd1);
`endif

      // Stop bit low on the third data byte.
      d0 = done_cnt;
      w0 = we_cnt;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'hDE, 1'b1);
      send_byte(8'hAD, 1'b1);
      send_byte(8'hBE, 1'b0);
      repeat (4) @(negedge clock);
      chk("D_err", {63'd0, err_o}, 64'd1);
      chk("D_hold", {63'd0, core_hold_o}, 64'd0);
      chk("D_busy", {63'd0, busy_o}, 64'd0);
      chk("D_no_write", 64'(we_cnt - w0), 64'd0);
      chk("D_no_done", 64'(done_cnt - d0), 64'd0);

      // Host stalls after two data bytes.
      w0 = we_cnt;
      send_byte(8'hA5, 1'b1);
      chk("E_err_clr", {63'd0, err_o}, 64'd0);
      send_byte(8'h01, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      repeat (TO - 200) @(negedge clock);
      chk("E_busy_pre", {63'd0, busy_o}, 64'd1);
      repeat (300) @(negedge clock);
      chk("E_err", {63'd0, err_o}, 64'd1);
      chk("E_hold", {63'd0, core_hold_o}, 64'd0);
      chk("E_busy", {63'd0, busy_o}, 64'd0);
      chk("E_no_write", 64'(we_cnt - w0), 64'd0);

      // Two-cycle low glitch while idle.
      b0 = bv_cnt;
      rx_i = 1'b0;
      repeat (2) @(negedge clock);
      rx_i = 1'b1;
      repeat (120) @(negedge clock);
      chk("G_no_byte", 64'(bv_cnt - b0), 64'd0);
      chk("G_idle", {63'd0, busy_o}, 64'd0);

      // Reset in the middle of the second data word.
      exp_q.push_back({32'h0, 32'h44332211});
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      send_byte(8'h55, 1'b1);
      chk("R_words_pre", {55'd0, words_o}, 64'd1);
      reset_i = 1'b0;
      #1;
      chk("R_ctl", {50'd0, mem_we_o, core_hold_o, busy_o, done_o, err_o, words_o}, 64'd0);
      chk("R_addr", {32'd0, mem_addr_o}, 64'd0);
      chk("R_data", {32'd0, mem_data_o}, 64'd0);
      repeat (3) @(negedge clock);
      reset_i = 1'b1;
      repeat (3) @(negedge clock);
      d0 = done_cnt;
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      chk("R_ignored", {63'd0, busy_o}, 64'd0);
      send_frame(8'h01, da, 8'h00);
      repeat (4) @(negedge clock);
      chk("R_done", 64'(done_cnt - d0), 64'd1);
      chk("R_words", {55'd0, words_o}, 64'd1);
      chk("R_err", {63'd0, err_o}, 64'd0);
      chk("R_drain", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      repeat (150000) @(negedge clock);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Serial program loader: receives a framed image on a UART line and writes 32-bit words into a core's instruction/data memory through a write port.
- While a frame is in progress, the target DLX core is held in reset.
- Sits beside the core/RAM/ROM trio at top level. It is the inbound path into the system; register values already go out on the board pins.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 2000000, maximum idle cycles between bytes inside a frame before abort.
- BASE_ADDR, 32'h0, byte address of the first written word.

Ports:
- clock  in  1  system clock; all state on posedge.
- reset_i  in  1  asynchronous, active-low reset.
- rx_i  in  1  UART receive line, idle high, asynchronous to clock.
- mem_we_o  out  1  one-cycle write strobe.
- mem_addr_o  out  32  byte address of the write (BASE_ADDR + 4*index).
- mem_data_o  out  32  word being written.
- core_hold_o  out  1  high while a frame is active; ORed into the core reset at top level.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse on successful frame end.
- err_o  out  1  sticky error flag; cleared by the next valid SYNC_BYTE.
- words_o  out  9  number of words written in the current/last frame.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, RX in idle. Reset mid-frame aborts immediately; words already written stay in memory.
- RX front end:
  - rx_i passes through a 2-flop synchronizer.
  - Start is detected on a falling edge, then the line is re-checked at CLKS_PER_BIT/2. If it is high there, the start was a glitch: ignore it and return to idle.
  - Data is sampled at bit centres, 8 bits LSB first, then the stop bit is sampled.
  - A byte_valid pulse is generated at the stop-bit sample, together with a stop_err flag (stop bit = 0).
- Frame format: SYNC_BYTE, N (word count; 0 means 256), 4*N data bytes little-endian, then an optional checksum (see Optional Feature).
- FSM states: IDLE, COUNT, DATA, CSUM, ERR.
  - IDLE: a byte equal to SYNC_BYTE → COUNT, clear err_o and words_o, assert core_hold_o. Any other byte is ignored. stop_err in IDLE is ignored.
  - COUNT: latch N (9 bits) → DATA; clear the byte index.
  - DATA: shift each byte into bits [8*k+7:8*k]. On the 4th byte, pulse mem_we_o in the cycle after byte_valid, with addr/data stable during the strobe. Then increment words_o. When words_o reaches N → CSUM if the feature is on, else → IDLE with done_o.
  - CSUM: compare the received byte with the running XOR → IDLE with done_o on match, → ERR on mismatch.
  - ERR: set err_o, drop core_hold_o, return to IDLE the next cycle.
- stop_err in any state other than IDLE → ERR. The partial word is discarded and not written.
- Timeout: a cycle counter resets on each byte_valid and counts in COUNT/DATA/CSUM. Reaching TIMEOUT_CYC → ERR.
- core_hold_o deasserts in the same cycle done_o pulses.
- Memory is written before the checksum is verified. err_o tells software and the operator that the image is invalid.
- An address past BASE_ADDR + 1020 cannot occur; N ≤ 256 bounds it.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined: the CSUM state exists; the running XOR of all 4*N data bytes (initial 8'h00) must equal the trailing byte.
- Undefined: no CSUM state and no XOR logic; the frame ends after the last data byte, and err_o arises only from stop-bit errors or timeout.

Decomposition:
- Shared package `loader_pkg`:
  - FSM state enum.
  - SYNC_BYTE default.
  - Frame field widths: count 9 bits, byte index 2 bits.
- Sub-module `uart_rx_byte`: synchronizer, bit timer, and shift register. Outputs byte_o[7:0], byte_valid_o and stop_err_o. Reused later for any console input.

Test Plan:
All scenarios use CLKS_PER_BIT=8 and TIMEOUT_CYC=2000.
- Frame A5,01,78,56,34,12 (+XOR 08) → one mem_we_o with addr 0, data 32'h12345678; done_o pulse; words_o=1; core_hold_o high from the COUNT byte until done.
- Frame A5,00 + 1024 bytes of the pattern i&FF (+ its checksum) → 256 writes, last addr 32'h3FC; words_o=256; done_o.
- Same as the first frame with checksum 09 (feature on) → write occurs, err_o=1, no done_o; the next valid frame clears err_o.
- Stop bit forced low on the 3rd data byte → ERR, no write, core_hold_o drops, err_o=1.
- Host stalls after 2 data bytes for more than 2000 cycles → ERR; a 2-cycle low glitch on rx_i in IDLE → no byte_valid.
- Reset (reset_i low) asserted mid-DATA → all outputs 0 immediately; garbage bytes 11,22 followed by a new A5 frame load correctly.
